// File: rtl/stopwatch_counter.sv
// -----------------------------------------------------------------------------
// stopwatch_counter
//
// Minutes:seconds stopwatch with three operating states:
//   RUN    - seconds advance on every tick_1Hz, carrying into minutes
//   PAUSED - count frozen, tick_1Hz ignored
//   ADJUST - tick_2Hz advances the field picked by select (no carry)
// A separate pause flag remembers whether the stopwatch should resume in
// RUN or PAUSED when adjust mode is left, and drives the paused output.
//
// Ports
//   clk        in   master clock
//   rst_n      in   asynchronous active-low reset
//   tick_1Hz   in   one-clk count enable
//   tick_2Hz   in   one-clk adjust enable
//   pause_btn  in   pause/resume request (pulse, or raw level, see below)
//   select     in   0 = adjust minutes, 1 = adjust seconds
//   adjust     in   level, 1 = adjust mode
//   minutes    out  registered minute count 0..59
//   seconds    out  registered second count 0..59
//   paused     out  registered pause flag
//   state_dbg  out  current FSM state (RUN=0, PAUSED=1, ADJUST=2)
//
// Build option
//   BTN_EDGE_EN  defined: pause_btn is a raw asynchronous level. It is
//                synchronized through two flops and the rising edge of the
//                synchronized level is the pause event, so a held button
//                gives exactly one event, three clocks after the pin rises.
//                undefined: pause_btn is already a clean one-clk synchronous
//                pulse; every cycle it is high is one pause event.
// -----------------------------------------------------------------------------
module stopwatch_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1Hz,
  input  logic       tick_2Hz,
  input  logic       pause_btn,
  input  logic       select,
  input  logic       adjust,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       paused,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  state_t state;
  logic   pause_ev;

  // ---------------------------------------------------------------------------
  // Pause event generation
  // ---------------------------------------------------------------------------
`ifdef BTN_EDGE_EN
  // btn_sync[0..1] are the synchronizer, btn_sync[2] is the edge-detect
  // history. All three are cleared by reset so a button held across reset
  // release still produces a fresh event.
  logic [2:0] btn_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 3'b000;
    end else begin
      btn_sync <= {btn_sync[1:0], pause_btn};
    end
  end

  assign pause_ev = btn_sync[1] & ~btn_sync[2];
`else
  assign pause_ev = pause_btn;
`endif

  // ---------------------------------------------------------------------------
  // Modulo-60 increment. Anything at or above 59 returns to 0, so even a
  // corrupted 60..63 value is pulled back into range on the next increment.
  // ---------------------------------------------------------------------------
  function automatic logic [5:0] inc60(input logic [5:0] v);
    if (v >= 6'd59) begin
      return 6'd0;
    end
    return v + 6'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Main FSM. Outputs are the registers themselves.
  // Priority inside RUN/PAUSED: adjust > pause event > tick. A pause event
  // or an adjust entry consumes the cycle, so a coincident tick is dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      paused  <= 1'b0;
      minutes <= 6'd0;
      seconds <= 6'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (adjust) begin
            state <= ST_ADJUST;
          end else if (pause_ev) begin
            state  <= ST_PAUSED;
            paused <= 1'b1;
          end else if (tick_1Hz) begin
            seconds <= inc60(seconds);
            if (seconds >= 6'd59) begin
              minutes <= inc60(minutes);
            end
          end
        end

        ST_PAUSED: begin
          if (adjust) begin
            state <= ST_ADJUST;
          end else if (pause_ev) begin
            state  <= ST_RUN;
            paused <= 1'b0;
          end
        end

        ST_ADJUST: begin
          // Pause events only flip the flag here; the flag (including a
          // toggle in the exit cycle) selects where adjust mode returns to.
          if (pause_ev) begin
            paused <= ~paused;
          end
          if (!adjust) begin
            state <= (paused ^ pause_ev) ? ST_PAUSED : ST_RUN;
          end else if (tick_2Hz) begin
            if (select) begin
              seconds <= inc60(seconds);
            end else begin
              minutes <= inc60(minutes);
            end
          end
        end

        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have port clk, input, 1, master clock; the only clock in the block.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port tick_1Hz, input, 1, one-clk-wide count enable at 1 Hz, synchronous to clk.
REQ-004 SHALL have port tick_2Hz, input, 1, one-clk-wide adjust enable at 2 Hz, synchronous to clk.
REQ-005 SHALL have port pause_btn, input, 1, pause/resume request.
REQ-006 SHALL have port select, input, 1: 0 = adjust minutes, 1 = adjust seconds.
REQ-007 SHALL have port adjust, input, 1, level; 1 = adjust mode.
REQ-008 SHALL have port minutes, output, 6, registered minute count, 0-59.
REQ-009 SHALL have port seconds, output, 6, registered second count, 0-59.
REQ-010 SHALL have port paused, output, 1, registered; 1 while the pause flag is set.

Function
REQ-011 SHALL implement a 3-state FSM with states RUN, PAUSED and ADJUST, plus a pause flag that records the non-adjust state.
REQ-012 RUN: on a clk edge with tick_1Hz=1, seconds SHALL increment by 1.
REQ-013 RUN, carry rule: seconds 59 -> 0 with minutes +1; 59:59 -> 00:00 with no overflow flag.
REQ-014 PAUSED: minutes and seconds SHALL hold, and tick_1Hz SHALL be ignored.
REQ-015 A pause event in RUN SHALL go to PAUSED and set paused=1; a pause event in PAUSED SHALL go to RUN and clear paused; the transition SHALL be visible on the next clk edge.
REQ-016 Pause event and tick_1Hz in the same cycle while in RUN: PAUSED SHALL be entered and the tick SHALL be dropped (count unchanged).
REQ-017 Pause event and tick_1Hz in the same cycle while in PAUSED: RUN SHALL be entered and the tick SHALL be dropped.
REQ-018 adjust=1 in RUN or PAUSED SHALL enter ADJUST on the next edge; ADJUST has priority over pause events.
REQ-019 ADJUST: tick_1Hz SHALL be ignored.
REQ-020 ADJUST: on tick_2Hz=1, the field chosen by select SHALL increment by 1, wrapping 59 -> 0, with no carry into the other field.
REQ-021 ADJUST: a select change SHALL take effect on the same cycle it is sampled.
REQ-022 ADJUST: pause events SHALL toggle the pause flag only, with no state change.
REQ-023 adjust=0 in ADJUST SHALL return to RUN if the pause flag is 0 and to PAUSED if it is 1.
REQ-024 Outputs SHALL update one clk after the cycle that samples the enabling tick (latency 1).
REQ-025 minutes and seconds SHALL never hold a value above 59 in any state.
REQ-026 An increment SHALL be applied only when the current value is 59 or less; values 60-63 are unreachable.

Reset
REQ-027 rst_n=0 SHALL immediately, regardless of clk, set minutes=0, seconds=0, paused=0, FSM=RUN and the pause flag=0.
REQ-028 Reset asserted mid-count or mid-adjust SHALL discard all state, including any pending edge-detect history.
REQ-029 After rst_n deasserts, the first tick_1Hz SHALL produce 00:01.

Configuration
REQ-030 Macro BTN_EDGE_EN, defined: pause_btn is a raw level; it SHALL pass through a 2-flop synchronizer, and a rising edge of the synchronized signal SHALL be the pause event (3-cycle latency from the pin to the event).
REQ-031 BTN_EDGE_EN, defined: a held button SHALL produce exactly one event.
REQ-032 Macro BTN_EDGE_EN, undefined: pause_btn SHALL be treated as a clean, one-clk-wide, synchronous pulse, and each cycle with pause_btn=1 SHALL be one pause event (0 extra latency).

Verification
REQ-033 Reset, then 75 tick_1Hz pulses -> minutes=1, seconds=15, paused=0.
REQ-034 Preload 59:59 via ADJUST, release adjust, 1 tick_1Hz -> 00:00.
REQ-035 At 00:10 in RUN, pause event plus tick_1Hz in the same cycle -> paused=1, 00:10 held through 5 more ticks; second pause event -> RUN, next tick gives 00:11.
REQ-036 PAUSED at 02:30, adjust=1, select=1, 31 tick_2Hz pulses -> 02:01 (no minute carry); then select=0, 58 tick_2Hz pulses -> 00:01; adjust=0 -> PAUSED, paused=1.
REQ-037 RUN at 05:05 in ADJUST, rst_n pulsed low between clk edges -> outputs 00:00 immediately, FSM=RUN after release.
REQ-038 BTN_EDGE_EN defined: pause_btn held high for 100 cycles -> exactly one toggle, observed 3 cycles after the pin rises.
